// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ==========================================================================
// Module : fifo_rd_ctrl
// Drains a fixed-latency FIFO into a credit-checked holding buffer feeding a
// valid/ready output stream.   Rev : 1.0
// ==========================================================================
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd,
    input  logic [DATA_WIDTH-1:0] iv_fifo_rdata,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] ov_data,
    output logic                  o_data_wr,
    output logic [CNT_WIDTH-1:0]  ov_rd_cnt,
    output logic                  o_buf_full
);

    localparam int ADDR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W  = ADDR_W + 1;
    localparam int CRED_W = ADDR_W + 2;
    localparam logic [OCC_W-1:0]  DEPTH_OCC  = OCC_W'(BUF_DEPTH);
    localparam logic [CRED_W-1:0] DEPTH_CRED = CRED_W'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic [RD_LATENCY-1:0] vld;
    logic [DATA_WIDTH-1:0] last_data;
    logic [CRED_W-1:0]     inflt;
    logic [CRED_W-1:0]     credits;
    logic                  push;
    logic                  pop;

    assign pop  = o_data_wr && i_ready;
    assign push = vld[RD_LATENCY-1];

    always_comb begin
        inflt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflt = inflt + CRED_W'(vld[i]);
        end
    end

    // A word popped this cycle frees its slot in time for a new read.
    assign credits   = CRED_W'(occ) + inflt - CRED_W'(pop);
    assign o_fifo_rd = i_rst_n && !i_fifo_empty && (credits < DEPTH_CRED);

    generate
        if (RD_LATENCY == 1) begin : g_dly_single
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld <= '0;
                end else begin
                    vld <= o_fifo_rd;
                end
            end
        end else begin : g_dly_shift
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld <= '0;
                end else begin
                    vld <= {vld[RD_LATENCY-2:0], o_fifo_rd};
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= iv_fifo_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            last_data <= '0;
            ov_rd_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                ov_rd_cnt <= ov_rd_cnt + CNT_WIDTH'(1);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!push && pop) begin
                occ <= occ - OCC_W'(1);
            end
            // Shadow of the presented word so the output holds once drained.
            if (occ != '0) begin
                last_data <= mem[rd_ptr];
            end
        end
    end

    assign o_data_wr  = (occ != '0);
    assign ov_data    = o_data_wr ? mem[rd_ptr] : last_data;
    assign o_buf_full = (occ == DEPTH_OCC);

endmodule
`default_nettype wire

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the 8-bit data path. It drains a synchronous FIFO with fixed read latency and presents the words downstream on the codebase's ov_data/o_data_wr stream. Downstream backpressure is handled through i_ready and an internal credit-managed holding buffer, so no word is dropped or duplicated. The block sits between the CDC/storage stage and the consumer logic, in a single clock domain.

Parameters:
DATA_WIDTH, 8, width of FIFO read data and output data.
RD_LATENCY, 1, cycles from o_fifo_rd high to valid iv_fifo_rdata; legal values 1 or 2.
BUF_DEPTH, 4, holding-buffer entries; must be >= RD_LATENCY+1 and a power of 2.
CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
i_clk  input  1  clock; all logic on the rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_fifo_empty  input  1  upstream FIFO empty flag; already reflects all reads issued in earlier cycles.
o_fifo_rd  output  1  FIFO read enable; one word per cycle it is high.
iv_fifo_rdata  input  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after o_fifo_rd.
i_ready  input  1  downstream can accept a word this cycle.
ov_data  output  DATA_WIDTH  output word, taken from the buffer head.
o_data_wr  output  1  ov_data valid; a word transfers when o_data_wr && i_ready.
ov_rd_cnt  output  CNT_WIDTH  count of transferred words, wraps modulo 2^CNT_WIDTH.
o_buf_full  output  1  holding buffer occupancy == BUF_DEPTH.

Behaviour:
- Reset (async assert, sync release): o_fifo_rd=0, ov_data=0, o_data_wr=0, ov_rd_cnt=0, o_buf_full=0. Buffer pointers, occupancy and in-flight count cleared.
- Credits: occ = buffer entries; inflt = reads issued whose data has not yet returned (0..RD_LATENCY).
- o_fifo_rd (combinational) = !i_fifo_empty && (occ + inflt − pop_this_cycle) < BUF_DEPTH, where pop = o_data_wr && i_ready.
- A delay line of RD_LATENCY registered valid bits tracks in-flight reads. When the tail bit is set, iv_fifo_rdata is written at the buffer write pointer.
- Buffer is a circular array with wr/rd pointers of log2(BUF_DEPTH) bits. Pointers wrap naturally. occ is held in a separate log2(BUF_DEPTH)+1-bit counter.
- Simultaneous push and pop: occ unchanged, both pointers advance. Pop from an empty buffer or push to a full buffer cannot occur by construction; either one is a design error (assertion in bench).
- o_data_wr = (occ != 0). ov_data = buf[rd_ptr] when occ != 0, else holds its last value.
- ov_data/o_data_wr must stay stable while o_data_wr && !i_ready.
- Latency with RD_LATENCY=1: o_fifo_rd at cycle t → data captured at edge t+1 → o_data_wr high from cycle t+2. Sustained throughput is 1 word/cycle when the FIFO is non-empty and i_ready=1.
- ov_rd_cnt increments by 1 on each transfer and wraps from 2^CNT_WIDTH−1 to 0.
- Words are delivered in exactly FIFO order with no loss or duplication under any i_ready pattern.
- Reset mid-operation: buffer and in-flight contents are discarded. Read data returning after reset release is ignored because the delay line is cleared.
- i_fifo_empty asserting while reads are in flight: in-flight data is still accepted, and no new reads are issued.

Test Plan:
- Reset, then 16 words 0x01..0x10 preloaded, i_ready=1 → o_fifo_rd high for 16 consecutive cycles; o_data_wr high for 16 consecutive cycles starting 2 cycles after the first rd; ov_data 0x01..0x10 in order; ov_rd_cnt=16.
- Same 16 words, i_ready=0 throughout → exactly 4 reads issued, o_buf_full=1, ov_data=0x01 held stable; after i_ready=1, words 0x01..0x10 delivered in order with no gaps or duplicates.
- Random i_ready (50%) over 200 words 0x00..0xC7 → scoreboard shows exact in-order match, no occ overflow/underflow assertion, ov_rd_cnt=200.
- Single word 0x5A, empty goes high next cycle → exactly one o_fifo_rd pulse and one transfer of 0x5A; o_data_wr is 0 afterwards.
- Reset asserted in the cycle after an o_fifo_rd with 3 words buffered → all outputs 0 immediately; returning data is not output; after release, fresh words 0x21,0x22 are delivered correctly with ov_rd_cnt=2.
- CNT_WIDTH=4, 18 words transferred → ov_rd_cnt wraps 15→0 and ends at 2.
